// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: Tnew width and the
// payload field layout that every stage uses to pack/unpack data_in/data_out.
package pipe_pkg;

  localparam int unsigned TNEW_W_DEFAULT = 3;
  localparam int unsigned PAYLOAD_W      = 64;

  // Payload field layout (LSB offset, width).
  localparam int unsigned INSTR_LSB  = 0;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned A3_LSB     = 32;
  localparam int unsigned A3_W       = 5;
  localparam int unsigned RFWE_LSB   = 37;
  localparam int unsigned DMWE_LSB   = 38;
  localparam int unsigned SELA3_LSB  = 39;
  localparam int unsigned SELA3_W    = 2;
  localparam int unsigned SELWD_LSB  = 41;
  localparam int unsigned SELWD_W    = 2;
  localparam int unsigned SELALUB_LSB = 43;
  localparam int unsigned ALUOP_LSB  = 44;
  localparam int unsigned ALUOP_W    = 4;
  localparam int unsigned DMOP_LSB   = 48;
  localparam int unsigned DMOP_W     = 3;

  // All-zero payload decodes as sll $0,$0,0 with every write enable low.
  localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: step only when enabled and not already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: PC, valid, Tnew and opaque payload with
// stall/flush handling and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W           = 64,
  parameter int unsigned       PC_W             = 32,
  parameter int unsigned       TNEW_W           = TNEW_W_DEFAULT,
  parameter bit                TNEW_DEC         = 1'b1,
  parameter bit                KEEP_PC_ON_FLUSH = 1'b0,
  parameter logic [DATA_W-1:0] RESET_DATA       = '0,
  parameter int unsigned       CNT_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [TNEW_W-1:0] tnew_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [TNEW_W-1:0] tnew_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TNEW_W-1:0] tnew_load;
  logic              bubble_inc;

  // Tnew captured on a normal load; bubbles never carry a pending result.
  always_comb begin
    tnew_load = '0;
    if (valid_in) begin
      if (TNEW_DEC) begin
        tnew_load = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);
      end else begin
        tnew_load = tnew_in;
      end
    end
  end

  // Next-state: flush beats stall beats load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    tnew_d  = tnew_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = KEEP_PC_ON_FLUSH ? pc_in : '0;
      tnew_d  = '0;
      data_d  = RESET_DATA;
    end else if (!stall) begin
      valid_d = valid_in;
      pc_d    = pc_in;
      tnew_d  = tnew_load;
      data_d  = data_in;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      tnew_q  <= '0;
      data_q  <= RESET_DATA;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      tnew_q  <= tnew_d;
      data_q  <= data_d;
    end
  end

  // A bubble is captured by a flush or by loading an invalid entry.
  assign bubble_inc = flush | (~stall & ~valid_in);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

  assign valid_out = valid_q;
  assign pc_out    = pc_q;
  assign tnew_out  = tnew_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two parameter variants driven in lockstep from a vector
// table, then saturation and a chained F/D-stall + D/E-flush sequence.
module tb_pipe_stage_reg;

  localparam logic [63:0] RDA = 64'h0000_0000_0000_00A5;
  localparam logic [63:0] RDB = 64'hFFFF_0000_0000_005A;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [31:0] pc = '0;
  logic [2:0]  tn = '0;
  logic [63:0] dat = '0;
  logic        fd_stall = 1'b0, de_flush = 1'b0;

  logic        va, vb, vfd, vde;
  logic [31:0] pca, pcb, pcfd, pcde;
  logic [2:0]  tna, tnb, tnfd, tnde;
  logic [63:0] da, db, dfd, dde;
  logic [31:0] cnta, cntfd, cntde;
  logic [3:0]  cntb;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  // A: decrementing Tnew, PC cleared on flush, 32-bit counter.
  pipe_stage_reg #(.DATA_W(64), .PC_W(32), .TNEW_W(3), .TNEW_DEC(1'b1),
    .KEEP_PC_ON_FLUSH(1'b0), .RESET_DATA(RDA), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid),
    .pc_in(pc), .tnew_in(tn), .data_in(dat), .valid_out(va), .pc_out(pca),
    .tnew_out(tna), .data_out(da), .bubble_cnt(cnta));

  // B: pass-through Tnew, PC kept on flush, 4-bit counter.
  pipe_stage_reg #(.DATA_W(64), .PC_W(32), .TNEW_W(3), .TNEW_DEC(1'b0),
    .KEEP_PC_ON_FLUSH(1'b1), .RESET_DATA(RDB), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid),
    .pc_in(pc), .tnew_in(tn), .data_in(dat), .valid_out(vb), .pc_out(pcb),
    .tnew_out(tnb), .data_out(db), .bubble_cnt(cntb));

  // Chained F/D -> D/E pair.
  pipe_stage_reg u_fd (
    .clk(clk), .reset(reset), .stall(fd_stall), .flush(1'b0), .valid_in(valid),
    .pc_in(pc), .tnew_in(tn), .data_in(dat), .valid_out(vfd), .pc_out(pcfd),
    .tnew_out(tnfd), .data_out(dfd), .bubble_cnt(cntfd));

  pipe_stage_reg u_de (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(de_flush), .valid_in(vfd),
    .pc_in(pcfd), .tnew_in(tnfd), .data_in(dfd), .valid_out(vde), .pc_out(pcde),
    .tnew_out(tnde), .data_out(dde), .bubble_cnt(cntde));

  typedef struct {
    logic        rst, stl, fls, vld;
    logic [31:0] pc;
    logic [2:0]  tn;
    logic [63:0] dat;
    logic        ev;
    logic [31:0] epc_a, epc_b;
    logic [2:0]  etn_a, etn_b;
    logic [63:0] ed_a, ed_b;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst stl fls vld pc        tn  dat     ev epc_a     epc_b     ta tb ed_a    ed_b    cnt
    vecs[0]  = '{1, 0, 0, 0, 32'h0,    0, 64'h0,    0, 32'h0,    32'h0,    0, 0, RDA,     RDB,     0};
    vecs[1]  = '{0, 0, 0, 1, 32'h3000, 2, 64'hDEAD, 1, 32'h3000, 32'h3000, 1, 2, 64'hDEAD, 64'hDEAD, 0};
    vecs[2]  = '{1, 1, 1, 1, 32'h3000, 2, 64'hDEAD, 0, 32'h0,    32'h0,    0, 0, RDA,     RDB,     0};
    vecs[3]  = '{0, 0, 0, 1, 32'h3000, 2, 64'h1111, 1, 32'h3000, 32'h3000, 1, 2, 64'h1111, 64'h1111, 0};
    vecs[4]  = '{0, 0, 0, 1, 32'h3004, 1, 64'h2222, 1, 32'h3004, 32'h3004, 0, 1, 64'h2222, 64'h2222, 0};
    vecs[5]  = '{0, 0, 0, 1, 32'h3008, 0, 64'h3333, 1, 32'h3008, 32'h3008, 0, 0, 64'h3333, 64'h3333, 0};
    vecs[6]  = '{0, 0, 0, 1, 32'h3004, 2, 64'h4444, 1, 32'h3004, 32'h3004, 1, 2, 64'h4444, 64'h4444, 0};
    vecs[7]  = '{0, 1, 0, 1, 32'h3008, 3, 64'h5555, 1, 32'h3004, 32'h3004, 1, 2, 64'h4444, 64'h4444, 0};
    vecs[8]  = '{0, 1, 0, 0, 32'h3008, 3, 64'h6666, 1, 32'h3004, 32'h3004, 1, 2, 64'h4444, 64'h4444, 0};
    vecs[9]  = '{0, 1, 0, 0, 32'h3008, 3, 64'h6666, 1, 32'h3004, 32'h3004, 1, 2, 64'h4444, 64'h4444, 0};
    vecs[10] = '{0, 0, 0, 1, 32'h3008, 3, 64'h5555, 1, 32'h3008, 32'h3008, 2, 3, 64'h5555, 64'h5555, 0};
    vecs[11] = '{0, 1, 1, 1, 32'h300C, 3, 64'h7777, 0, 32'h0,    32'h300C, 0, 0, RDA,     RDB,     1};
    vecs[12] = '{0, 0, 0, 0, 32'h3010, 3, 64'h8888, 0, 32'h3010, 32'h3010, 0, 0, 64'h8888, 64'h8888, 2};
    vecs[13] = '{0, 0, 1, 1, 32'h3014, 5, 64'hAAAA, 0, 32'h0,    32'h3014, 0, 0, RDA,     RDB,     3};
    vecs[14] = '{0, 0, 0, 1, 32'h3018, 7, 64'h9999, 1, 32'h3018, 32'h3018, 6, 7, 64'h9999, 64'h9999, 3};
    vecs[15] = '{0, 1, 0, 0, 32'h301C, 1, 64'hBBBB, 1, 32'h3018, 32'h3018, 6, 7, 64'h9999, 64'h9999, 3};

    #2;
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fls; valid = vecs[i].vld;
      pc = vecs[i].pc; tn = vecs[i].tn; dat = vecs[i].dat;
      step();
      check($sformatf("v%0d valid_a", i), 64'(va), 64'(vecs[i].ev));
      check($sformatf("v%0d valid_b", i), 64'(vb), 64'(vecs[i].ev));
      check($sformatf("v%0d pc_a", i), 64'(pca), 64'(vecs[i].epc_a));
      check($sformatf("v%0d pc_b", i), 64'(pcb), 64'(vecs[i].epc_b));
      check($sformatf("v%0d tnew_a", i), 64'(tna), 64'(vecs[i].etn_a));
      check($sformatf("v%0d tnew_b", i), 64'(tnb), 64'(vecs[i].etn_b));
      check($sformatf("v%0d data_a", i), da, vecs[i].ed_a);
      check($sformatf("v%0d data_b", i), db, vecs[i].ed_b);
      check($sformatf("v%0d cnt_a", i), 64'(cnta), 64'(vecs[i].ecnt));
      check($sformatf("v%0d cnt_b", i), 64'(cntb), 64'(vecs[i].ecnt));
    end

    // Saturation: 20 flushes, 4-bit counter sticks at 15, 32-bit keeps going.
    reset = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b1;
    step();
    check("sat pre-reset cnt_b", 64'(cntb), 64'd0);
    reset = 1'b0; flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sat%0d cnt_b", i), 64'(cntb), (i + 1 > 15) ? 64'd15 : 64'(i + 1));
      check($sformatf("sat%0d cnt_a", i), 64'(cnta), 64'(i + 1));
    end
    flush = 1'b0; reset = 1'b1;
    step();
    check("sat reset cnt_b", 64'(cntb), 64'd0);
    check("sat reset cnt_a", 64'(cnta), 64'd0);

    // Chained F/D stall + D/E flush: bubble, then the held entry passes once.
    reset = 1'b0; valid = 1'b1; pc = 32'h3010; tn = 3'd2; dat = 64'hC0DE;
    step();
    check("chain fd pc load", 64'(pcfd), 64'h3010);
    fd_stall = 1'b1; de_flush = 1'b1; pc = 32'h3014; dat = 64'hC0DF;
    step();
    check("chain fd pc held", 64'(pcfd), 64'h3010);
    check("chain de bubble valid", 64'(vde), 64'd0);
    check("chain de bubble pc", 64'(pcde), 64'd0);
    check("chain de bubble data", dde, 64'd0);
    fd_stall = 1'b0; de_flush = 1'b0;
    step();
    check("chain de pc", 64'(pcde), 64'h3010);
    check("chain de valid", 64'(vde), 64'd1);
    check("chain de data", dde, 64'hC0DE);
    check("chain de tnew", 64'(tnde), 64'd0);
    check("chain fd pc next", 64'(pcfd), 64'h3014);
    pc = 32'h3018; dat = 64'hC0E0;
    step();
    check("chain de pc next", 64'(pcde), 64'h3014);
    check("chain de valid next", 64'(vde), 64'd1);
    check("chain de cnt", 64'(cntde), 64'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
